// File: rtl/kf8237_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : kf8237_bus_arbiter_if
// Description : Bus-side signal bundle for the KF8237 bus arbiter. Carries the
//               HRQ/HLDA handshake, CPU bus status, DMA address path and the
//               page-register write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface kf8237_bus_arbiter_if;
  logic        cpu_clock;
  logic        hold_request;
  logic        cpu_bus_idle;
  logic        cpu_lock_n;
  logic        hold_acknowledge;
  logic        dma_bus_owner;
  logic [3:0]  dma_acknowledge;
  logic [15:0] address_in;
  logic [19:0] address_out;
  logic        page_select_n;
  logic        io_write_n;
  logic [1:0]  io_address;
  logic [7:0]  data_bus_in;
  logic        dma_timeout;

  // Environment side: CPU bus unit and 8237 drive the requests.
  modport master (
    output cpu_clock, hold_request, cpu_bus_idle, cpu_lock_n,
           dma_acknowledge, address_in, page_select_n, io_write_n,
           io_address, data_bus_in,
    input  hold_acknowledge, dma_bus_owner, address_out, dma_timeout
  );

  // Arbiter side.
  modport slave (
    input  cpu_clock, hold_request, cpu_bus_idle, cpu_lock_n,
           dma_acknowledge, address_in, page_select_n, io_write_n,
           io_address, data_bus_in,
    output hold_acknowledge, dma_bus_owner, address_out, dma_timeout
  );
endinterface
`default_nettype wire

// File: rtl/kf8237_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : kf8237_bus_arbiter
// Description : Sequences system bus ownership between the CPU and the KF8237
//               DMA controller (HRQ/HLDA handshake with a one-cycle release
//               turnaround), holds the four DMA page registers, forms the
//               20-bit DMA address and flags over-long DMA holds.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8237_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  kf8237_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic        grant_entry;
  logic        prev_cpu_clock;
  logic        prev_io_write_n;
  logic        cpu_posedge;
  logic        page_commit;
  logic [1:0]  write_channel;
  logic [3:0]  page [4];
  logic [3:0]  page_bits;
  logic [15:0] hold_count;
  logic [16:0] hold_count_inc;
  logic        hold_count_at_limit;
  logic        timeout_flag;
  logic        unused_data_high;

  // Only the low nibble of the CPU data bus feeds the page registers.
  assign unused_data_high = ^bus.data_bus_in[7:4];

  assign cpu_posedge = ~prev_cpu_clock & bus.cpu_clock;
  assign page_commit = ~prev_io_write_n & bus.io_write_n & ~bus.page_select_n;

  // Edge-detect history for the CPU clock and the I/O write strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_cpu_clock  <= 1'b0;
      prev_io_write_n <= 1'b1;
    end else begin
      prev_cpu_clock  <= bus.cpu_clock;
      prev_io_write_n <= bus.io_write_n;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every move waits for a CPU clock rising edge.
  always_comb begin
    state_next  = state;
    grant_entry = 1'b0;
    if (cpu_posedge) begin
      case (state)
        ST_IDLE: begin
          if (bus.hold_request) state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.hold_request) begin
            state_next = ST_IDLE;
          end else if (bus.cpu_bus_idle && bus.cpu_lock_n) begin
            state_next  = ST_GRANT;
            grant_entry = 1'b1;
          end
        end
        ST_GRANT: begin
          if (!bus.hold_request) state_next = ST_RELEASE;
        end
        ST_RELEASE: begin
          // Turnaround cycle; any new request re-arbitrates from IDLE.
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.hold_acknowledge = (state == ST_GRANT);
  assign bus.dma_bus_owner    = (state == ST_GRANT) || (state == ST_RELEASE);

  assign hold_count_inc      = {1'b0, hold_count} + 17'd1;
  assign hold_count_at_limit = ({1'b0, hold_count} >= TIMEOUT_LIMIT);

  // Hold-duration counter with a sticky flag; it never forces a release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_count   <= 16'd0;
      timeout_flag <= 1'b0;
    end else if (grant_entry) begin
      hold_count   <= 16'd0;
      timeout_flag <= 1'b0;
    end else if (cpu_posedge && (state == ST_GRANT) && !hold_count_at_limit) begin
      hold_count <= hold_count_inc[15:0];
      if (hold_count_inc == TIMEOUT_LIMIT) timeout_flag <= 1'b1;
    end
  end

  assign bus.dma_timeout = timeout_flag;

  // Register-select decode: the port order is ch0, ch2, ch3, ch1.
  always_comb begin
    write_channel = 2'd0;
    case (bus.io_address)
      2'b00: write_channel = 2'd0;
      2'b01: write_channel = 2'd2;
      2'b10: write_channel = 2'd3;
      2'b11: write_channel = 2'd1;
      default: write_channel = 2'd0;
    endcase
  end

  // Page registers commit on the rising edge of the I/O write strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) page[i] <= 4'h0;
    end else if (page_commit) begin
      page[write_channel] <= bus.data_bus_in[3:0];
    end
  end

  // Page nibble is only applied while DMA owns the bus with a clean one-hot DACK.
  always_comb begin
    page_bits = 4'h0;
    if (bus.dma_bus_owner) begin
      case (bus.dma_acknowledge)
        4'b0001: page_bits = page[0];
        4'b0010: page_bits = page[1];
        4'b0100: page_bits = page[2];
        4'b1000: page_bits = page[3];
        default: page_bits = 4'h0;
      endcase
    end
  end

  assign bus.address_out = {page_bits, bus.address_in};

endmodule
`default_nettype wire

// File: tb/tb_kf8237_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_kf8237_bus_arbiter
// Description : Self-checking bench for kf8237_bus_arbiter (TIMEOUT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kf8237_bus_arbiter;

  localparam int SIG_HLDA  = 0;
  localparam int SIG_OWNER = 1;
  localparam int SIG_TMO   = 2;
  localparam int SIG_ADDR  = 3;

  typedef struct packed {
    logic [3:0]  dack;
    logic [15:0] ain;
    logic [19:0] exp_addr;
  } vec_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  string       name_q[$];
  int          sig_q[$];
  logic [19:0] exp_q[$];

  vec_t vecs [8];

  kf8237_bus_arbiter_if bus ();

  kf8237_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [19:0] dut_value(input int sig);
    case (sig)
      SIG_HLDA:  return {19'd0, bus.hold_acknowledge};
      SIG_OWNER: return {19'd0, bus.dma_bus_owner};
      SIG_TMO:   return {19'd0, bus.dma_timeout};
      default:   return bus.address_out;
    endcase
  endfunction

  task automatic expect_sig(input string name, input int sig, input logic [19:0] value);
    name_q.push_back(name);
    sig_q.push_back(sig);
    exp_q.push_back(value);
  endtask

  task automatic expect_bus(input string name, input logic hlda, input logic owner);
    expect_sig({name, "_hlda"}, SIG_HLDA, {19'd0, hlda});
    expect_sig({name, "_owner"}, SIG_OWNER, {19'd0, owner});
  endtask

  task automatic sb_drain();
    string       n;
    int          s;
    logic [19:0] e;
    logic [19:0] a;
    while (exp_q.size() != 0) begin
      n = name_q.pop_front();
      s = sig_q.pop_front();
      e = exp_q.pop_front();
      a = dut_value(s);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  endtask

  // One CPU clock cycle; sampling point is 1ns after the edge that saw the rise.
  task automatic cpu_edge();
    @(negedge clock);
    bus.cpu_clock = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    bus.cpu_clock = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic page_write(input logic [1:0] sel, input logic [7:0] data);
    @(negedge clock);
    bus.page_select_n = 1'b0;
    bus.io_address    = sel;
    bus.data_bus_in   = data;
    bus.io_write_n    = 1'b0;
    @(negedge clock);
    bus.io_write_n    = 1'b1;
    @(negedge clock);
    bus.page_select_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{dack: 4'b0001, ain: 16'h1234, exp_addr: 20'h11234};
    vecs[1] = '{dack: 4'b0100, ain: 16'h1234, exp_addr: 20'h51234};
    vecs[2] = '{dack: 4'b0010, ain: 16'h1234, exp_addr: 20'h91234};
    vecs[3] = '{dack: 4'b1000, ain: 16'hABCD, exp_addr: 20'hCABCD};
    vecs[4] = '{dack: 4'b0110, ain: 16'h1234, exp_addr: 20'h01234};
    vecs[5] = '{dack: 4'b0000, ain: 16'hFFFF, exp_addr: 20'h0FFFF};
    vecs[6] = '{dack: 4'b1111, ain: 16'h5A5A, exp_addr: 20'h05A5A};
    vecs[7] = '{dack: 4'b0001, ain: 16'h0000, exp_addr: 20'h10000};

    bus.cpu_clock       = 1'b0;
    bus.hold_request    = 1'b0;
    bus.cpu_bus_idle    = 1'b1;
    bus.cpu_lock_n      = 1'b1;
    bus.dma_acknowledge = 4'b0001;
    bus.address_in      = 16'h1234;
    bus.page_select_n   = 1'b1;
    bus.io_write_n      = 1'b1;
    bus.io_address      = 2'b00;
    bus.data_bus_in     = 8'h00;
    reset_n             = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    expect_bus("reset", 1'b0, 1'b0);
    expect_sig("reset_tmo", SIG_TMO, 20'd0);
    expect_sig("reset_addr", SIG_ADDR, 20'h01234);
    sb_drain();
    @(negedge clock);
    reset_n = 1'b1;

    // Basic grant: always via WAIT, HLDA on the 2nd CPU edge
    bus.hold_request = 1'b1;
    cpu_edge(); expect_bus("grant_p1", 1'b0, 1'b0); sb_drain();
    cpu_edge(); expect_bus("grant_p2", 1'b1, 1'b1); sb_drain();
    bus.hold_request = 1'b0;
    repeat (5) @(posedge clock);
    #1; expect_bus("grant_no_cpu_edge", 1'b1, 1'b1); sb_drain();
    cpu_edge(); expect_bus("release_p1", 1'b0, 1'b1); sb_drain();
    cpu_edge(); expect_bus("release_p2", 1'b0, 1'b0); sb_drain();

    // Request seen in RELEASE waits for fresh arbitration
    bus.hold_request = 1'b1;
    cpu_edge(); cpu_edge();
    bus.hold_request = 1'b0;
    cpu_edge(); expect_bus("rearb_release", 1'b0, 1'b1); sb_drain();
    bus.hold_request = 1'b1;
    cpu_edge(); expect_bus("rearb_idle", 1'b0, 1'b0); sb_drain();
    cpu_edge(); expect_bus("rearb_wait", 1'b0, 1'b0); sb_drain();
    cpu_edge(); expect_bus("rearb_grant", 1'b1, 1'b1); sb_drain();
    bus.hold_request = 1'b0;
    cpu_edge(); cpu_edge();

    // Lock inhibit
    bus.cpu_lock_n   = 1'b0;
    bus.hold_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_edge(); expect_bus("lock_inhibit", 1'b0, 1'b0); sb_drain();
    end
    bus.cpu_lock_n = 1'b1;
    cpu_edge(); expect_bus("lock_released", 1'b1, 1'b1); sb_drain();
    bus.hold_request = 1'b0;
    cpu_edge(); cpu_edge();

    // Busy inhibit, then HRQ drops in WAIT
    bus.cpu_bus_idle = 1'b0;
    bus.hold_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_edge(); expect_bus("busy_inhibit", 1'b0, 1'b0); sb_drain();
    end
    bus.hold_request = 1'b0;
    cpu_edge(); expect_bus("wait_abort", 1'b0, 1'b0); sb_drain();
    bus.cpu_bus_idle = 1'b1;
    bus.hold_request = 1'b1;
    cpu_edge(); expect_bus("wait_abort_idle", 1'b0, 1'b0); sb_drain();
    cpu_edge(); expect_bus("wait_abort_regrant", 1'b1, 1'b1); sb_drain();
    bus.hold_request = 1'b0;
    cpu_edge(); cpu_edge();

    // Page register load and address formation table
    page_write(2'b00, 8'h01);
    page_write(2'b01, 8'h05);
    page_write(2'b10, 8'h0C);
    page_write(2'b11, 8'h09);
    bus.dma_acknowledge = 4'b0001;
    expect_sig("addr_idle_no_page", SIG_ADDR, 20'h01234); sb_drain();
    bus.hold_request = 1'b1;
    cpu_edge(); cpu_edge();
    for (int i = 0; i < 8; i++) begin
      bus.dma_acknowledge = vecs[i].dack;
      bus.address_in      = vecs[i].ain;
      #1;
      expect_sig($sformatf("addr_vec%0d", i), SIG_ADDR, vecs[i].exp_addr);
      sb_drain();
    end

    // Write strobe is edge-triggered and select is sampled at the rising edge
    bus.dma_acknowledge = 4'b0100;
    bus.address_in      = 16'h1234;
    @(negedge clock);
    bus.page_select_n = 1'b0;
    bus.io_address    = 2'b01;
    bus.data_bus_in   = 8'hFA;
    bus.io_write_n    = 1'b0;
    repeat (10) @(posedge clock);
    #1; expect_sig("strobe_low_hold", SIG_ADDR, 20'h51234); sb_drain();
    @(negedge clock);
    bus.io_write_n = 1'b1;
    @(posedge clock);
    #1; expect_sig("strobe_commit", SIG_ADDR, 20'hA1234); sb_drain();
    @(negedge clock);
    bus.data_bus_in = 8'h03;
    bus.io_write_n  = 1'b0;
    @(negedge clock);
    bus.io_write_n    = 1'b1;
    bus.page_select_n = 1'b1;
    repeat (2) @(posedge clock);
    #1; expect_sig("strobe_deselected", SIG_ADDR, 20'hA1234); sb_drain();

    // Turnaround keeps the page applied; IDLE drops it
    bus.hold_request = 1'b0;
    cpu_edge(); expect_sig("addr_release", SIG_ADDR, 20'hA1234); sb_drain();
    cpu_edge(); expect_sig("addr_after_release", SIG_ADDR, 20'h01234); sb_drain();

    // Timeout at the 4th CPU edge in GRANT, sticky through release
    bus.hold_request = 1'b1;
    cpu_edge(); cpu_edge();
    expect_sig("tmo_entry", SIG_TMO, 20'd0); sb_drain();
    for (int i = 1; i <= 6; i++) begin
      cpu_edge();
      expect_sig($sformatf("tmo_edge%0d", i), SIG_TMO, (i >= 4) ? 20'd1 : 20'd0);
      expect_bus("tmo_no_release", 1'b1, 1'b1);
      sb_drain();
    end
    bus.hold_request = 1'b0;
    cpu_edge(); expect_sig("tmo_sticky_release", SIG_TMO, 20'd1); sb_drain();
    cpu_edge(); expect_sig("tmo_sticky_idle", SIG_TMO, 20'd1); sb_drain();
    bus.hold_request = 1'b1;
    cpu_edge(); expect_sig("tmo_sticky_wait", SIG_TMO, 20'd1); sb_drain();
    cpu_edge(); expect_sig("tmo_cleared_regrant", SIG_TMO, 20'd0); sb_drain();

    // Reset mid-GRANT drops ownership immediately and clears pages
    for (int i = 0; i < 4; i++) cpu_edge();
    expect_sig("pre_reset_tmo", SIG_TMO, 20'd1);
    expect_sig("pre_reset_addr", SIG_ADDR, 20'hA1234);
    sb_drain();
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    expect_bus("mid_reset", 1'b0, 1'b0);
    expect_sig("mid_reset_tmo", SIG_TMO, 20'd0);
    expect_sig("mid_reset_addr", SIG_ADDR, 20'h01234);
    sb_drain();
    @(negedge clock);
    reset_n = 1'b1;
    cpu_edge(); cpu_edge();
    expect_bus("post_reset_grant", 1'b1, 1'b1);
    expect_sig("post_reset_page2", SIG_ADDR, 20'h01234);
    sb_drain();
    bus.dma_acknowledge = 4'b0010;
    #1; expect_sig("post_reset_page1", SIG_ADDR, 20'h01234); sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kf8237_bus_arbiter.md
# kf8237_bus_arbiter

Sits between the CPU bus unit and the KF8237 DMA controller and sequences bus ownership. It handles the 8237 HRQ/HLDA handshake, waits for an idle, unlocked CPU bus cycle, and drives the bus-owner select. It holds the four write-only DMA page registers and forms the 20-bit DMA address. It also flags a DMA hold that lasts too long.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cpu_clock cycles in GRANT before dma_timeout is set; legal range 1..65535.

Ports:
- clock  in  1  system clock; all logic is on posedge.
- reset_n  in  1  reset, synchronous and active-low.
- cpu_clock  in  1  CPU clock, sampled on clock; state advances only on its rising edge.
- hold_request  in  1  HRQ from the 8237.
- cpu_bus_idle  in  1  CPU status is passive (no bus cycle in progress).
- cpu_lock_n  in  1  CPU LOCK; low inhibits any grant.
- hold_acknowledge  out  1  HLDA to the 8237.
- dma_bus_owner  out  1  1 = DMA drives the system bus; 0 = CPU drives it.
- dma_acknowledge  in  4  DACK[3:0] from the 8237, active-high one-hot.
- address_in  in  16  8237 address_out.
- address_out  out  20  system DMA address.
- page_select_n  in  1  chip select for the page register block.
- io_write_n  in  1  CPU I/O write strobe.
- io_address  in  2  register select: 00 = ch0, 01 = ch2, 10 = ch3, 11 = ch1.
- data_bus_in  in  8  CPU data; bits [3:0] are used.
- dma_timeout  out  1  sticky flag, set when a hold exceeds the limit.

## Operation
- cpu_clock_posedge is detected as ~prev & cur, with prev registered on clock. Every state transition and every counter step is qualified by this pulse.
- State machine:
  - IDLE: hold_acknowledge = 0, dma_bus_owner = 0. On a posedge with hold_request = 1, go to WAIT.
  - WAIT: on a posedge, act in this priority order:
    - hold_request = 0: return to IDLE with no grant.
    - hold_request = 1, cpu_bus_idle = 1 and cpu_lock_n = 1: go to GRANT.
    - otherwise: stay in WAIT.
  - GRANT: hold_acknowledge = 1, dma_bus_owner = 1. On a posedge with hold_request = 0, go to RELEASE.
  - RELEASE: hold_acknowledge = 0, dma_bus_owner stays 1 for exactly one cpu_clock cycle as a bus turnaround. On the next posedge, go to IDLE. A hold_request seen in RELEASE is not honoured until IDLE → WAIT re-arbitrates.
- Page registers:
  - Four 4-bit registers.
  - A write commits on the clock where prev_io_write_n = 0, io_write_n = 1 and page_select_n = 0; page_select_n is sampled on that same clock.
  - Writes are accepted in every state.
- Address formation (combinational):
  - address_out = {page[ch], address_in} when dma_bus_owner = 1 and dma_acknowledge is exactly one-hot.
  - In every other case, address_out = {4'h0, address_in}.
- Timeout:
  - A 16-bit counter clears on entry to GRANT and increments on each posedge while in GRANT.
  - When the counter reaches TIMEOUT_CYCLES, dma_timeout is set to 1 and the counter saturates.
  - dma_timeout clears only on reset or on the next entry to GRANT. Reaching the limit does not force a release.

## Timing
- Reset values:
  - State IDLE; hold_acknowledge = 0, dma_bus_owner = 0, dma_timeout = 0.
  - All page registers = 0, counter = 0, prev registers = 1 (prev_cpu_clock = 0).
  - address_out = {4'h0, address_in}.
- Grant latency: at least 2 cpu_clock posedges from HRQ rising, one for IDLE→WAIT and one for WAIT→GRANT. Outputs change on the clock edge that registers the posedge pulse.
- Release latency: hold_acknowledge falls 1 cpu_clock posedge after HRQ falls. dma_bus_owner falls one cpu_clock posedge later.
- A page write during GRANT is visible on address_out on the clock after the commit.
- When reset_n is asserted mid-GRANT, hold_acknowledge and dma_bus_owner drop on the next clock, with no turnaround.
- When HRQ and the bus-idle condition are both true on the same posedge in IDLE, the block still passes through WAIT; it never goes IDLE → GRANT directly.

## Test plan
- Basic grant: reset, then HRQ = 1 with cpu_bus_idle = 1 and cpu_lock_n = 1 → hold_acknowledge = 1 at the 2nd cpu posedge. Drop HRQ → HLDA = 0 after 1 posedge, dma_bus_owner = 0 after 2 posedges.
- Lock and busy inhibit: HRQ = 1 with cpu_lock_n = 0 for 5 cycles → no grant. Release the lock → grant on the next posedge. Drop HRQ while in WAIT → return to IDLE, HLDA never asserted.
- Page addressing: write 0x5 to io_address 01 and 0x9 to 11. In GRANT with DACK = 0100 and address_in = 16'h1234 → address_out = 20'h51234. With DACK = 0010 → 20'h91234. With DACK = 0110 → 20'h01234.
- Write-strobe edge: hold io_write_n low for 10 clocks → the register keeps its old value until the rising edge. A strobe with page_select_n = 1 → no change.
- Timeout: TIMEOUT_CYCLES = 4, hold GRANT for 6 posedges → dma_timeout = 1 from the 4th posedge and stays set after release. The next grant clears it.
- Reset mid-operation: assert reset_n = 0 in GRANT with pages loaded → next clock HLDA = 0, owner = 0, all pages = 0.
